// File: rtl/seq_pattern_gen.sv
// Serial pattern generator: sends a latched pattern MSB-first on sout, with repeats and idle gaps.
// Optional even-parity bit per frame when SEQ_GEN_PARITY_EN is defined.
module seq_pattern_gen #(
  parameter int MAX_LEN = 16,
  localparam int LEN_W  = $clog2(MAX_LEN + 1)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   length,
  input  logic [7:0]         repeat_cnt,
  input  logic [3:0]         gap,
  input  logic               abort,
  output logic               sout,
  output logic               sout_vld,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam int IDX_W = $clog2(MAX_LEN);

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    GAP,
`ifdef SEQ_GEN_PARITY_EN
    PAR,
`endif
    FIN
  } state_e;

  state_e             state_q, state_d;
  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [7:0]         rep_q, rep_d;
  logic [3:0]         gap_q, gap_d;
  logic [IDX_W-1:0]   bit_q, bit_d;
  logic [3:0]         gcnt_q, gcnt_d;
  logic [8:0]         frame_q, frame_d;
  logic               sout_q, sout_d;
  logic               vld_q, vld_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               frame_over;

`ifdef SEQ_GEN_PARITY_EN
  logic par_bit;

  always_comb begin
    par_bit = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (i < int'(len_q)) par_bit ^= pat_q[i];
    end
  end
`endif

  always_comb begin
    // NOTE: every _d gets a default first, so no path through this block can infer a latch.
    state_d    = state_q;
    pat_d      = pat_q;
    len_d      = len_q;
    rep_d      = rep_q;
    gap_d      = gap_q;
    bit_d      = bit_q;
    gcnt_d     = gcnt_q;
    frame_d    = frame_q;
    err_d      = 1'b0;
    frame_over = 1'b0;

    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          if (length == '0 || length > LEN_W'(MAX_LEN)) begin
            err_d = 1'b1;
          end else begin
            state_d = SHIFT;
            pat_d   = pattern;
            len_d   = length;
            rep_d   = repeat_cnt;
            gap_d   = gap;
            bit_d   = IDX_W'(length - 1'b1);
            frame_d = '0;
          end
        end
      end
      SHIFT: begin
        if (abort) begin
          state_d = IDLE;
        end else if (bit_q != '0) begin
          bit_d = bit_q - 1'b1;
        end else begin
`ifdef SEQ_GEN_PARITY_EN
          state_d = PAR;
`else
          frame_over = 1'b1;
`endif
        end
      end
`ifdef SEQ_GEN_PARITY_EN
      PAR: begin
        if (abort) state_d = IDLE;
        else       frame_over = 1'b1;
      end
`endif
      GAP: begin
        if (abort) begin
          state_d = IDLE;
        end else if (gcnt_q == 4'd1) begin
          state_d = SHIFT;
          bit_d   = IDX_W'(len_q - 1'b1);
        end else begin
          gcnt_d = gcnt_q - 4'd1;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // End of a frame on the wire: finish, rest in GAP, or reload straight into SHIFT.
    if (frame_over) begin
      if (frame_q == {1'b0, rep_q}) begin
        state_d = FIN;
      end else begin
        frame_d = frame_q + 9'd1;
        if (gap_q != 4'd0) begin
          state_d = GAP;
          gcnt_d  = gap_q;
        end else begin
          state_d = SHIFT;
          bit_d   = IDX_W'(len_q - 1'b1);
        end
      end
    end

    // Outputs are decoded from the next state so they can be registered alongside it.
    sout_d = 1'b0;
    vld_d  = 1'b0;
    busy_d = 1'b0;
    case (state_d)
      SHIFT: begin
        sout_d = pat_d[bit_d];
        vld_d  = 1'b1;
        busy_d = 1'b1;
      end
`ifdef SEQ_GEN_PARITY_EN
      PAR: begin
        sout_d = par_bit;
        vld_d  = 1'b1;
        busy_d = 1'b1;
      end
`endif
      GAP:     busy_d = 1'b1;
      default: busy_d = 1'b0;
    endcase
    done_d = (state_d == FIN);
  end

  // NOTE: sequential state uses non-blocking assignments only, avoiding ordering races between blocks.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pat_q   <= '0;
      len_q   <= '0;
      rep_q   <= '0;
      gap_q   <= '0;
      bit_q   <= '0;
      gcnt_q  <= '0;
      frame_q <= '0;
      sout_q  <= 1'b0;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      rep_q   <= rep_d;
      gap_q   <= gap_d;
      bit_q   <= bit_d;
      gcnt_q  <= gcnt_d;
      frame_q <= frame_d;
      sout_q  <= sout_d;
      vld_q   <= vld_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign sout     = sout_q;
  assign sout_vld = vld_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule
